// File: rtl/adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// adder_rr_arbiter : round-robin share of one WIDTH-bit adder, 1-cycle response.
// Optional carry-out on resp_ovf when ADDER_RR_ARBITER_OVF_EN is defined.
// Revision: 1.0
// ============================================================================
module adder_rr_arbiter #(
   parameter  int WIDTH = 32,
   parameter  int N_REQ = 4,
   localparam int IDW   = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [IDW-1:0]         resp_id,
   output logic [WIDTH-1:0]       resp_sum,
   output logic                   resp_ovf,
   output logic                   busy
);

   logic [IDW-1:0]   r_rr_ptr;
   logic             r_resp_valid;
   logic [IDW-1:0]   r_resp_id;
   logic [WIDTH-1:0] r_resp_sum;

   logic [IDW-1:0]   w_grant;
   logic [IDW-1:0]   w_ptr_next;
   logic             w_found;
   logic             w_slot_free;
   logic             w_accept;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_sum;

   assign w_slot_free = !r_resp_valid || resp_ready;

   // First valid requester found scanning upward from r_rr_ptr, wrapping.
   always_comb begin
      int idx;
      w_found = 1'b0;
      w_grant = '0;
      idx     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(r_rr_ptr) + k) % N_REQ;
         if (!w_found && req_valid[idx]) begin
            w_found = 1'b1;
            w_grant = idx[IDW-1:0];
         end
      end
   end

   // Gated by rst_n so nothing is handshaken while reset is held.
   always_comb begin
      req_ready = '0;
      if (rst_n && w_slot_free && w_found) begin
         req_ready[w_grant] = 1'b1;
      end
   end

   assign w_accept   = |req_ready;
   assign w_ptr_next = (w_grant == IDW'(N_REQ - 1)) ? '0 : w_grant + 1'b1;

   assign w_a = req_a[int'(w_grant)*WIDTH +: WIDTH];
   assign w_b = req_b[int'(w_grant)*WIDTH +: WIDTH];

`ifdef ADDER_RR_ARBITER_OVF_EN
   logic [WIDTH:0] w_full;
   logic           r_resp_ovf;

   assign w_full = {1'b0, w_a} + {1'b0, w_b};
   assign w_sum  = w_full[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_ovf <= 1'b0;
      end else if (w_accept) begin
         r_resp_ovf <= w_full[WIDTH];
      end
   end

   assign resp_ovf = r_resp_ovf;
`else
   assign w_sum    = w_a + w_b;
   assign resp_ovf = 1'b0;
`endif

   // Accept has priority over drain, so a simultaneous drain+accept leaves no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_valid <= 1'b0;
         r_resp_id    <= '0;
         r_resp_sum   <= '0;
         r_rr_ptr     <= '0;
      end else if (w_accept) begin
         r_resp_valid <= 1'b1;
         r_resp_id    <= w_grant;
         r_resp_sum   <= w_sum;
         r_rr_ptr     <= w_ptr_next;
      end else if (resp_ready) begin
         r_resp_valid <= 1'b0;
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_id    = r_resp_id;
   assign resp_sum   = r_resp_sum;
   assign busy       = r_resp_valid | (|req_valid);

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_adder_rr_arbiter : directed bench with a behavioural reference model.
// Revision: 1.0
// ============================================================================
module tb_adder_rr_arbiter;

   localparam int WIDTH = 32;
   localparam int N_REQ = 4;
   localparam int IDW   = 2;
`ifdef ADDER_RR_ARBITER_OVF_EN
   localparam logic c_ovf_wrap = 1'b1;
`else
   localparam logic c_ovf_wrap = 1'b0;
`endif

   logic                   clk;
   logic                   rst_n;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [IDW-1:0]         resp_id;
   logic [WIDTH-1:0]       resp_sum;
   logic                   resp_ovf;
   logic                   busy;

   int n_cmp  = 0;
   int n_fail = 0;

   adder_rr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .resp_ovf   (resp_ovf),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
   endtask

   task automatic after_pos();
      @(posedge clk);
      #1;
   endtask

   // Reference model: response slot contents plus round-robin pointer.
   logic        saw_rst = 1'b0;
   logic        m_valid;
   int          m_id;
   int          m_ptr;
   logic [31:0] m_sum;
   logic        m_ovf;

   always @(negedge rst_n) saw_rst = 1'b1;

   initial begin
      int               best;
      int               bestd;
      int               d;
      logic [N_REQ-1:0] exp_ready;
      logic [32:0]      full;
      m_valid = 1'b0; m_id = 0; m_ptr = 0; m_sum = '0; m_ovf = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n || saw_rst) begin
            m_valid = 1'b0; m_id = 0; m_ptr = 0; m_sum = '0; m_ovf = 1'b0;
         end
         saw_rst = 1'b0;
         // Winner = valid requester with the smallest forward distance from the pointer.
         best  = -1;
         bestd = N_REQ;
         for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i]) begin
               d = (i - m_ptr + N_REQ) % N_REQ;
               if (d < bestd) begin
                  bestd = d;
                  best  = i;
               end
            end
         end
         exp_ready = '0;
         if (rst_n && (!m_valid || resp_ready) && best >= 0) exp_ready[best] = 1'b1;
         chk("model_req_ready",  64'(req_ready),  64'(exp_ready));
         chk("model_resp_valid", 64'(resp_valid), 64'(m_valid));
         chk("model_resp_id",    64'(resp_id),    64'(m_id));
         chk("model_resp_sum",   64'(resp_sum),   64'(m_sum));
         chk("model_resp_ovf",   64'(resp_ovf),   64'(m_ovf));
         chk("model_busy",       64'(busy),       64'(m_valid | (|req_valid)));
         if (exp_ready != '0) begin
            full    = {1'b0, req_a[best*WIDTH +: WIDTH]} + {1'b0, req_b[best*WIDTH +: WIDTH]};
            m_valid = 1'b1;
            m_id    = best;
            m_sum   = full[31:0];
            m_ovf   = c_ovf_wrap ? full[32] : 1'b0;
            m_ptr   = (best + 1) % N_REQ;
         end else if (rst_n && resp_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   initial begin
      int exp_g[6];
      exp_g = '{3, 0, 1, 2, 3, 0};

      rst_n      = 1'b0;
      req_valid  = 4'hF;
      resp_ready = 1'b1;
      req_a      = '0;
      req_b      = '0;

      // Reset held with all requesters valid
      repeat (2) @(negedge clk);
      chk("rst_req_ready",  64'(req_ready),  64'h0);
      chk("rst_resp_valid", 64'(resp_valid), 64'h0);
      chk("rst_resp_id",    64'(resp_id),    64'h0);
      chk("rst_resp_sum",   64'(resp_sum),   64'h0);
      after_pos();
      rst_n     = 1'b1;
      req_valid = 4'b0000;

      // Single request from requester 2
      after_pos();
      set_op(2, 32'd5, 32'd7);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("single_ready", 64'(req_ready), 64'h4);
      after_pos();
      req_valid = 4'b0000;
      @(negedge clk);
      chk("single_valid", 64'(resp_valid), 64'h1);
      chk("single_id",    64'(resp_id),    64'h2);
      chk("single_sum",   64'(resp_sum),   64'd12);

      // Round robin with all valid; pointer starts at 3 after the grant to 2
      after_pos();
      for (int i = 0; i < N_REQ; i++) set_op(i, 32'(100*i + 7), 32'(i));
      req_valid = 4'hF;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("rr_grant", 64'(req_ready), 64'(4'b0001 << exp_g[c]));
         if (c > 0) begin
            chk("rr_valid", 64'(resp_valid), 64'h1);
            chk("rr_id",    64'(resp_id),    64'(exp_g[c-1]));
            chk("rr_sum",   64'(resp_sum),   64'(101*exp_g[c-1] + 7));
         end
         after_pos();
      end

      // Back-pressure: response for requester 0 held for 3 cycles
      resp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_valid", 64'(resp_valid), 64'h1);
         chk("bp_id",    64'(resp_id),    64'h0);
         chk("bp_sum",   64'(resp_sum),   64'd7);
         chk("bp_ready", 64'(req_ready),  64'h0);
         after_pos();
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_grant", 64'(req_ready), 64'h2);
      after_pos();
      @(negedge clk);
      chk("bp_release_valid", 64'(resp_valid), 64'h1);
      chk("bp_release_id",    64'(resp_id),    64'h1);
      chk("bp_release_sum",   64'(resp_sum),   64'd108);

      // Wrap: 0xFFFF_FFFF + 1 on requester 2
      after_pos();
      set_op(2, 32'hFFFF_FFFF, 32'd1);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("wrap_ready", 64'(req_ready), 64'h4);
      after_pos();
      req_valid  = 4'b0000;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("wrap_id",  64'(resp_id),  64'h2);
      chk("wrap_sum", 64'(resp_sum), 64'h0);
      chk("wrap_ovf", 64'(resp_ovf), 64'(c_ovf_wrap));

      // Mid-flight reset with response held and requests pending
      after_pos();
      req_valid = 4'hF;
      @(negedge clk);
      chk("mid_pending_ready", 64'(req_ready),  64'h0);
      chk("mid_pending_valid", 64'(resp_valid), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(resp_valid), 64'h0);
      chk("mid_rst_sum",   64'(resp_sum),   64'h0);
      chk("mid_rst_id",    64'(resp_id),    64'h0);
      chk("mid_rst_ready", 64'(req_ready),  64'h0);
      after_pos();
      rst_n      = 1'b1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_first", 64'(req_ready), 64'h1);

      // Sparse pattern and idle drain, checked by the model
      after_pos();
      req_valid = 4'b1010;
      repeat (4) after_pos();
      req_valid = 4'b0000;
      repeat (3) after_pos();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
